// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control path.
//   state_t     FSM states; the encoding is exported on state_dbg.
//   op_class_t  instruction class produced by the opcode decoder.
//   OP_*        RV32I-subset major opcodes.
//   ALU_ADD/SUB ALU function codes shared with the ALU and control decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

endpackage

// File: rtl/ctrl_opdecode.sv
// ctrl_opdecode: combinational opcode/funct decoder.
//   opcode, funct3, funct7b5  instruction fields from the IR
//   op_class                  instruction class (CLS_ILLEGAL for unknown opcodes)
//   alu_op                    ALU function, zero-extended to ALU_OP_W
//   alu_src                   ALU B operand is the immediate
//   legal                     opcode is one of the supported classes
module ctrl_opdecode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int ALU_OP_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  output op_class_t           op_class,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                legal
);

  logic [3:0] alu4;

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu4     = ALU_ADD;
    alu_src  = 1'b0;
    case (opcode)
      OPCODE_W'(OP_R): begin
        op_class = CLS_R;
        alu4     = {funct7b5, funct3};
      end
      OPCODE_W'(OP_I): begin
        op_class = CLS_I;
        // only SRAI carries funct7b5 into the ALU; for other I-types bit 30 is immediate data
        alu4     = {funct7b5 & (funct3 == 3'b101), funct3};
        alu_src  = 1'b1;
      end
      OPCODE_W'(OP_LOAD): begin
        op_class = CLS_LOAD;
        alu_src  = 1'b1;
      end
      OPCODE_W'(OP_STORE): begin
        op_class = CLS_STORE;
        alu_src  = 1'b1;
      end
      OPCODE_W'(OP_BRANCH): begin
        op_class = CLS_BRANCH;
        alu4     = ALU_SUB;
      end
      default: op_class = CLS_ILLEGAL;
    endcase
    legal  = (op_class != CLS_ILLEGAL);
    alu_op = ALU_OP_W'(alu4);
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RV32I-subset control path.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives registered datapath strobes.
//   clk, reset              clock and synchronous active-high reset
//   run                     start/continue enable (sampled in IDLE and WB)
//   opcode/funct3/funct7b5  IR fields, valid from DECODE onward
//   alu_zero                ALU zero flag, valid in EXEC
//   imem_ready, dmem_ready  memory acknowledges
//   ifetch_req, ir_wr, pc_wr, brnch, mem_rd, mem_wr, mem_to_rgs,
//   alu_src, reg_wr, alu_op datapath controls
//   busy, illegal, timeout, state_dbg  status and debug
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int ALU_OP_W = 4,
  parameter int TMO_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                alu_zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                ifetch_req,
  output logic                ir_wr,
  output logic                pc_wr,
  output logic                brnch,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_to_rgs,
  output logic                alu_src,
  output logic                reg_wr,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                busy,
  output logic                illegal,
  output logic                timeout,
  output logic [2:0]          state_dbg
);

  localparam logic [TMO_W-1:0] CNT_ONE = TMO_W'(1);
  localparam logic [TMO_W-1:0] CNT_ALL = '1;

  state_t              state_q, state_d;
  op_class_t           cls_q, cls_d;
  logic                fetched_q, fetched_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                expire, set_ill, set_tmo;
  logic                brnch_en_q, brnch_en_d;

  logic                ifetch_req_d, ir_wr_d, pc_wr_d, mem_rd_d, mem_wr_d;
  logic                mem_to_rgs_d, alu_src_d, reg_wr_d, busy_d;
  logic [ALU_OP_W-1:0] alu_op_d;

  op_class_t           dec_class;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_alu_src, dec_legal;

  ctrl_opdecode #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_opdecode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .op_class (dec_class),
    .alu_op   (dec_alu_op),
    .alu_src  (dec_alu_src),
    .legal    (dec_legal)
  );

  assign cnt_inc = cnt_q + CNT_ONE;
  assign expire  = (cnt_inc == CNT_ALL);

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    fetched_d = 1'b0;
    cnt_d     = cnt_q;
    set_ill   = 1'b0;
    set_tmo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        // fetched_q marks the single IR/PC load cycle that follows the ack
        if (fetched_q) begin
          state_d = DECODE;
        end else if (imem_ready) begin
          fetched_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (expire) begin
            state_d = TRAP;
            set_tmo = 1'b1;
          end
        end
      end
      DECODE: begin
        if (dec_legal) begin
          state_d = EXEC;
          cls_d   = dec_class;
        end else begin
          state_d = TRAP;
          set_ill = 1'b1;
        end
      end
      EXEC: begin
        cnt_d = '0;
        case (cls_q)
          CLS_BRANCH:           state_d = FETCH;
          CLS_LOAD, CLS_STORE:  state_d = MEM;
          default:              state_d = WB;
        endcase
      end
      MEM: begin
        if (dmem_ready) begin
          state_d = (cls_q == CLS_STORE) ? FETCH : WB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (expire) begin
            state_d = TRAP;
            set_tmo = 1'b1;
          end
        end
      end
      WB: begin
        cnt_d   = '0;
        state_d = run ? FETCH : IDLE;
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase

    // Outputs are computed for the state being entered and registered with it.
    ifetch_req_d = (state_d == FETCH) && !fetched_d;
    ir_wr_d      = fetched_d;
    pc_wr_d      = fetched_d;
    mem_rd_d     = (state_d == MEM) && (cls_d == CLS_LOAD);
    mem_wr_d     = (state_d == MEM) && (cls_d == CLS_STORE);
    reg_wr_d     = (state_d == WB);
    mem_to_rgs_d = (state_d == WB) && (cls_d == CLS_LOAD);
    alu_src_d    = (state_d == EXEC) && dec_alu_src;
    alu_op_d     = (state_d == EXEC) ? dec_alu_op : '0;
    brnch_en_d   = (state_d == EXEC) && (dec_class == CLS_BRANCH);
    busy_d       = !(state_d inside {IDLE, TRAP});
  end

  // ---- state / output register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cls_q      <= CLS_R;
      fetched_q  <= 1'b0;
      cnt_q      <= '0;
      brnch_en_q <= 1'b0;
      ifetch_req <= 1'b0;
      ir_wr      <= 1'b0;
      pc_wr      <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_to_rgs <= 1'b0;
      alu_src    <= 1'b0;
      reg_wr     <= 1'b0;
      alu_op     <= '0;
      busy       <= 1'b0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      fetched_q  <= fetched_d;
      cnt_q      <= cnt_d;
      brnch_en_q <= brnch_en_d;
      ifetch_req <= ifetch_req_d;
      ir_wr      <= ir_wr_d;
      pc_wr      <= pc_wr_d;
      mem_rd     <= mem_rd_d;
      mem_wr     <= mem_wr_d;
      mem_to_rgs <= mem_to_rgs_d;
      alu_src    <= alu_src_d;
      reg_wr     <= reg_wr_d;
      alu_op     <= alu_op_d;
      busy       <= busy_d;
      illegal    <= illegal | set_ill;
      timeout    <= timeout | set_tmo;
    end
  end

  // alu_zero only becomes valid during EXEC, so the taken decision is qualified
  // there by a strobe that was registered on entry to EXEC.
  assign brnch     = brnch_en_q & alu_zero;
  assign state_dbg = state_q;

endmodule
